bin_to_bcd_digits: RTL



---
 rtl/bin_to_bcd_digits_pkg.sv | 19 +
 rtl/bin_to_bcd_digits_bcd_add3.sv | 17 +
 rtl/bin_to_bcd_digits.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared display codes and converter FSM encoding for the 7-segment digit path.
// The segment LUT side imports the same codes so both ends agree on minus/blank.
package bin_to_bcd_digits_pkg;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    // BCD nibbles needed to hold any WIDTH-bit magnitude (including 2^(WIDTH-1)).
    function automatic int nib_count(input int width);
        return (width + 32'sd2) / 32'sd3;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digits_bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential signed binary to display-code converter: one double-dabble shift per
// clock, then a formatting step with leading-zero blanking, minus sign and overflow.
module bin_to_bcd_digits
    import bin_to_bcd_digits_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NDIG     = 8,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [4*NDIG-1:0]   digits
);

    localparam int NB = nib_count(WIDTH);
    localparam int PN = (NB > NDIG) ? NB : NDIG;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    state_t             state_r, state_nxt;
    logic               sign_r, sign_nxt;
    logic [WIDTH-1:0]   mag_r, mag_nxt;
    logic [4*NB-1:0]    bcd_r, bcd_nxt;
    logic [CW-1:0]      cnt_r, cnt_nxt;
    logic               busy_r, busy_nxt;
    logic               done_r, done_nxt;
    logic               ovf_r, ovf_nxt;
    logic [4*NDIG-1:0]  digits_r, digits_nxt;

    logic [WIDTH-1:0]   abs_s;
    logic [4*NB-1:0]    adj_s;
    logic [4*PN-1:0]    bcd_pad_s;
    int                 lead_i;
    int                 need_i;
    logic               fmt_ovf_s;
    logic [4*NDIG-1:0]  fmt_digits_s;

    // The most negative input negates to itself, which reads correctly as unsigned.
    assign abs_s = value[WIDTH-1] ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

    for (genvar g = 0; g < NB; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // Leading-digit search, overflow test and display-code placement
    always_comb begin
        bcd_pad_s            = '0;
        bcd_pad_s[4*NB-1:0]  = bcd_r;
        lead_i               = 32'sd0;
        for (int i = 0; i < NB; i++) begin
            if (bcd_r[4*i +: 4] != 4'h0) begin
                lead_i = i;
            end else begin
                lead_i = lead_i;
            end
        end
        need_i       = lead_i + 32'sd1 + (sign_r ? 32'sd1 : 32'sd0);
        fmt_ovf_s    = (need_i > NDIG);
        fmt_digits_s = {NDIG{CODE_BLANK}};
        for (int i = 0; i < NDIG; i++) begin
            if (fmt_ovf_s) begin
                fmt_digits_s[4*i +: 4] = CODE_MINUS;
            end else if (BLANK_LZ != 0) begin
                if (i <= lead_i) begin
                    fmt_digits_s[4*i +: 4] = bcd_pad_s[4*i +: 4];
                end else if (sign_r && (i == lead_i + 32'sd1)) begin
                    fmt_digits_s[4*i +: 4] = CODE_MINUS;
                end else begin
                    fmt_digits_s[4*i +: 4] = CODE_BLANK;
                end
            end else begin
                if (sign_r && (i == NDIG - 1)) begin
                    fmt_digits_s[4*i +: 4] = CODE_MINUS;
                end else begin
                    fmt_digits_s[4*i +: 4] = bcd_pad_s[4*i +: 4];
                end
            end
        end
    end

    // FSM next-state and datapath next values
    always_comb begin
        state_nxt  = state_r;
        sign_nxt   = sign_r;
        mag_nxt    = mag_r;
        bcd_nxt    = bcd_r;
        cnt_nxt    = cnt_r;
        busy_nxt   = busy_r;
        done_nxt   = 1'b0;
        ovf_nxt    = ovf_r;
        digits_nxt = digits_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sign_nxt  = value[WIDTH-1];
                    mag_nxt   = abs_s;
                    bcd_nxt   = '0;
                    cnt_nxt   = CNT_LOAD;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                {bcd_nxt, mag_nxt} = {adj_s, mag_r} << 1;
                cnt_nxt            = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt = FORMAT;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            FORMAT: begin
                ovf_nxt    = fmt_ovf_s;
                digits_nxt = fmt_digits_s;
                done_nxt   = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and blanks the display
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            sign_r   <= 1'b0;
            mag_r    <= '0;
            bcd_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            digits_r <= {NDIG{CODE_BLANK}};
        end else begin
            state_r  <= state_nxt;
            sign_r   <= sign_nxt;
            mag_r    <= mag_nxt;
            bcd_r    <= bcd_nxt;
            cnt_r    <= cnt_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            ovf_r    <= ovf_nxt;
            digits_r <= digits_nxt;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;
    assign digits = digits_r;

endmodule
